alu_wb_drain: RTL
=================

Name: alu_wb_drain

Overview:
- Consumer end of an ALU writeback queue.
- Watches the queue head, requests a register-file write slot from the RFA, and commits the head entry once the slot is granted.
- A commit is one registered cycle: VGPR write, SGPR write, VCC/exec write and instruction-done to issue.
- In the same cycle it pulses the entry-serviced strobe back to the queue, so the head advances.

Parameters:
- CNT_W, 16, width of the saturating retired-entry counter.
- MAX_WAIT, 255, number of request cycles without a grant before the sticky timeout flag sets.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- in_queue_empty  input  1  queue has no valid head entry
- in_vgpr_dest_data  input  2048  head VGPR data
- in_sgpr_dest_data  input  64  head SGPR data
- in_exec_wr_vcc_value  input  64  head VCC value
- in_vgpr_wr_mask  input  64  head lane write mask
- in_wfid  input  6  head wavefront id
- in_instr_pc  input  32  head PC
- in_vgpr_dest_addr  input  10  head VGPR address
- in_sgpr_dest_addr  input  9  head SGPR address
- in_vgpr_dest_wr_en  input  1  head VGPR write enable
- in_sgpr_dest_wr_en  input  1  head SGPR write enable
- in_vcc_wr_en  input  1  head VCC write enable
- in_rfa_grant  input  1  RFA grants the write slot this cycle
- out_rfa_request  output  1  request for a write slot
- out_entry_serviced  output  1  one-cycle pop strobe to the queue
- out_vgpr_wr_en  output  1  VGPR write strobe
- out_vgpr_wr_addr  output  10  VGPR write address
- out_vgpr_wr_data  output  2048  VGPR write data
- out_vgpr_wr_mask  output  64  VGPR lane mask
- out_sgpr_wr_en  output  1  SGPR write strobe
- out_sgpr_wr_addr  output  9  SGPR write address
- out_sgpr_wr_data  output  64  SGPR write data
- out_vcc_wr_en  output  1  VCC write strobe
- out_vcc_value  output  64  VCC value
- out_instr_done  output  1  instruction retired
- out_instr_done_wfid  output  6  wfid of the retired instruction
- out_instr_done_pc  output  32  PC of the retired instruction
- out_retired_count  output  CNT_W  saturating count of commits
- out_grant_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (rst low, async): state IDLE; every output is 0; wait and retired counters are 0; timeout flag clear. While rst is low, no serviced pulse is produced. A reset during COMMIT aborts the strobes immediately, and the queue head is not advanced.
- States: IDLE, REQ, COMMIT.
- IDLE:
  - out_rfa_request=0.
  - If in_queue_empty=0, go to REQ next cycle.
- REQ:
  - out_rfa_request=1 (combinational from state).
  - If in_rfa_grant=1, capture all head fields into the output registers and go to COMMIT.
  - Otherwise stay in REQ.
  - A grant seen outside REQ is ignored.
- COMMIT (exactly one cycle):
  - out_entry_serviced=1.
  - out_vgpr_wr_en, out_sgpr_wr_en and out_vcc_wr_en equal the captured enables.
  - out_instr_done=1 always, including an entry with all enables 0.
  - Next state is IDLE. This gives the queue head and empty flag one edge to update, so an entry is never committed twice.
- Latency: grant in cycle n gives write strobes and serviced pulse in cycle n+1. Request re-asserts no earlier than n+3.
- Data outputs hold their last captured values; only the enables and strobes return to 0 after COMMIT.
- out_retired_count:
  - Increments on every COMMIT.
  - Saturates at 2^CNT_W-1.
- Watchdog:
  - The wait counter increments each REQ cycle without a grant and clears on grant.
  - When the count reaches MAX_WAIT, out_grant_timeout sets and stays set until reset.
  - The FSM keeps requesting.
- Empty in REQ: if in_queue_empty rises while in REQ without a grant (queue flushed), return to IDLE and clear the wait counter.
- Simultaneous grant and empty rise in REQ: empty wins; no commit.

Test Plan:
- Reset release with empty=1 for 10 cycles -> request, serviced and all enables stay 0; count=0.
- One entry (wfid=5, pc=0x100, vgpr addr=0x3A, mask=0xFFFF, vgpr_wr_en=1), grant at cycle 3 -> cycle 4: vgpr_wr_en=1 with addr 0x3A, serviced=1, instr_done=1 with wfid 5; sgpr/vcc enables 0; count=1.
- Three back-to-back entries with grant held high -> exactly 3 serviced pulses, each 3 cycles apart; captured PCs match in order; count=3.
- Entry with all wr_en=0 -> instr_done=1 and serviced=1, no write strobes.
- Grant withheld for 300 cycles with MAX_WAIT=255 -> timeout sets at the 255th wait cycle and stays set; a later grant still commits.
- rst driven low during COMMIT -> serviced and strobes drop to 0 without waiting for a clock edge; after release, the same head entry commits once.

Source files
------------

// File: rtl/alu_wb_drain.sv
// Drain side of the ALU writeback queue. Requests a register-file write slot
// for the queue head, captures the head fields on grant, and spends exactly one
// cycle in COMMIT driving the write strobes, instruction-done and pop pulse.
module alu_wb_drain #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_queue_empty,
    input  logic [2047:0]      in_vgpr_dest_data,
    input  logic [63:0]        in_sgpr_dest_data,
    input  logic [63:0]        in_exec_wr_vcc_value,
    input  logic [63:0]        in_vgpr_wr_mask,
    input  logic [5:0]         in_wfid,
    input  logic [31:0]        in_instr_pc,
    input  logic [9:0]         in_vgpr_dest_addr,
    input  logic [8:0]         in_sgpr_dest_addr,
    input  logic               in_vgpr_dest_wr_en,
    input  logic               in_sgpr_dest_wr_en,
    input  logic               in_vcc_wr_en,
    input  logic               in_rfa_grant,
    output logic               out_rfa_request,
    output logic               out_entry_serviced,
    output logic               out_vgpr_wr_en,
    output logic [9:0]         out_vgpr_wr_addr,
    output logic [2047:0]      out_vgpr_wr_data,
    output logic [63:0]        out_vgpr_wr_mask,
    output logic               out_sgpr_wr_en,
    output logic [8:0]         out_sgpr_wr_addr,
    output logic [63:0]        out_sgpr_wr_data,
    output logic               out_vcc_wr_en,
    output logic [63:0]        out_vcc_value,
    output logic               out_instr_done,
    output logic [5:0]         out_instr_done_wfid,
    output logic [31:0]        out_instr_done_pc,
    output logic [CNT_W-1:0]   out_retired_count,
    output logic               out_grant_timeout
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               capture;

    // Captured head entry; data holds between commits, enables only matter in COMMIT.
    logic               vgpr_en_q, sgpr_en_q, vcc_en_q;
    logic [9:0]         vgpr_addr_q;
    logic [2047:0]      vgpr_data_q;
    logic [63:0]        vgpr_mask_q;
    logic [8:0]         sgpr_addr_q;
    logic [63:0]        sgpr_data_q;
    logic [63:0]        vcc_value_q;
    logic [5:0]         wfid_q;
    logic [31:0]        pc_q;

    logic               in_commit;

    // Next-state logic: an empty head in REQ wins over a same-cycle grant.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        count_d   = count_q;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (!in_queue_empty) state_d = REQ;
            end
            REQ: begin
                if (in_queue_empty) begin
                    state_d = IDLE;
                    wait_d  = '0;
                end else if (in_rfa_grant) begin
                    state_d = COMMIT;
                    capture = 1'b1;
                    wait_d  = '0;
                end else if (wait_q != WAIT_LIMIT) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                wait_d  = '0;
            end
        endcase
        timeout_d = timeout_q | (wait_d == WAIT_LIMIT);
    end

    // State, watchdog and retired counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    // Head capture on grant; these registers feed the write ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vgpr_en_q   <= 1'b0;
            sgpr_en_q   <= 1'b0;
            vcc_en_q    <= 1'b0;
            vgpr_addr_q <= '0;
            vgpr_data_q <= '0;
            vgpr_mask_q <= '0;
            sgpr_addr_q <= '0;
            sgpr_data_q <= '0;
            vcc_value_q <= '0;
            wfid_q      <= '0;
            pc_q        <= '0;
        end else if (capture) begin
            vgpr_en_q   <= in_vgpr_dest_wr_en;
            sgpr_en_q   <= in_sgpr_dest_wr_en;
            vcc_en_q    <= in_vcc_wr_en;
            vgpr_addr_q <= in_vgpr_dest_addr;
            vgpr_data_q <= in_vgpr_dest_data;
            vgpr_mask_q <= in_vgpr_wr_mask;
            sgpr_addr_q <= in_sgpr_dest_addr;
            sgpr_data_q <= in_sgpr_dest_data;
            vcc_value_q <= in_exec_wr_vcc_value;
            wfid_q      <= in_wfid;
            pc_q        <= in_instr_pc;
        end
    end

    // Strobes decode from the state register, so a reset in COMMIT drops them at once.
    assign in_commit           = (state_q == COMMIT);
    assign out_rfa_request     = (state_q == REQ);
    assign out_entry_serviced  = in_commit;
    assign out_instr_done      = in_commit;
    assign out_vgpr_wr_en      = in_commit & vgpr_en_q;
    assign out_sgpr_wr_en      = in_commit & sgpr_en_q;
    assign out_vcc_wr_en       = in_commit & vcc_en_q;
    assign out_vgpr_wr_addr    = vgpr_addr_q;
    assign out_vgpr_wr_data    = vgpr_data_q;
    assign out_vgpr_wr_mask    = vgpr_mask_q;
    assign out_sgpr_wr_addr    = sgpr_addr_q;
    assign out_sgpr_wr_data    = sgpr_data_q;
    assign out_vcc_value       = vcc_value_q;
    assign out_instr_done_wfid = wfid_q;
    assign out_instr_done_pc   = pc_q;
    assign out_retired_count   = count_q;
    assign out_grant_timeout   = timeout_q;

endmodule
